cv_mem_mapper: RTL and testbench
================================

CV_MEM_MAPPER -- requirements
Module: cv_mem_mapper

Interface
REQ-001 Parameter: PAGE_W, 6, width of the ROM page number in 16 KB units (6 gives up to 1 MB).
REQ-002 Parameter: SEGA_BANKS, 3, number of Sega-mapper slot registers (slots at 0000/4000/8000); legal values 1..3.
REQ-003 Port: clk_i  input  1  system clock; single clock domain.
REQ-004 Port: reset_n_i  input  1  reset, synchronous, active-low.
REQ-005 Port: mode_i  input  2  mapper mode: 0 plain Coleco, 1 MegaCart, 2 Sega, 3 plain Coleco.
REQ-006 Port: a_i  input  16  Z80 address bus.
REQ-007 Port: d_i  input  8  Z80 data bus, write data.
REQ-008 Port: cart_pages_i  input  PAGE_W  cartridge size minus one, in 16 KB pages; used as the page mask.
REQ-009 Port: mreq_n_i / iorq_n_i / rd_n_i / wr_n_i / rfsh_n_i  input  1 each  Z80 strobes, active-low.
REQ-010 Port: rom_page_o  output  PAGE_W  16 KB cartridge page for the current address.
REQ-011 Port: rom_ce_n_o / bios_ce_n_o / ram_ce_n_o  output  1 each  chip enables, active-low.
REQ-012 Port: bios_en_o / upper_ram_en_o  output  1 each  current SGM state bits.

Function
REQ-013 Define a memory access as mreq_n_i=0 and rfsh_n_i=1; decode SHALL be combinational from a_i, and register updates SHALL be visible from the next clk_i edge.
REQ-014 Enables outside a memory access: all enables SHALL be 1. During an access, exactly one enable SHALL be 0.
REQ-015 Modes 0/1, 0000-1FFF: bios_ce_n_o=0 if bios_en, else ram_ce_n_o=0; 2000-7FFF: ram_ce_n_o=0.
REQ-016 Modes 0/1, 8000-FFFF: ram_ce_n_o=0 if upper_ram_en, else rom_ce_n_o=0.
REQ-017 Mode 0 page: 8000-BFFF gives 0, C000-FFFF gives 1; page SHALL be masked with cart_pages_i.
REQ-018 Mode 1 page: 8000-BFFF gives cart_pages_i (last page); C000-FFFF gives the mc_page register.
REQ-019 Mode 1: a memory read (rd_n_i=0) at FFC0-FFFF SHALL load mc_page with a_i[PAGE_W-1:0] & cart_pages_i, where a_i bits above 5 are treated as zero when PAGE_W>6; the decoded access itself SHALL still use the old page.
REQ-020 Mode 2: C000-FFFF gives ram_ce_n_o=0; 0000-BFFF gives rom_ce_n_o=0, with page = bank[a_i[15:14]] & cart_pages_i. Slots at or above SEGA_BANKS SHALL use the fixed page (slot index).
REQ-021 Mode 2: a memory write to FFFD+n (n<SEGA_BANKS) SHALL load bank[n] with d_i[PAGE_W-1:0]; RAM SHALL also be written (ram_ce_n_o=0).
REQ-022 An I/O write (iorq_n_i=0, wr_n_i=0, mreq_n_i=1) to port 7F SHALL load bios_en with d_i[1], except in mode 2, where bios_en SHALL be forced to 0 every cycle.
REQ-023 Updates are level-based: a held strobe rewrites the same value, and the result is idempotent.
REQ-024 A mode_i change SHALL take effect combinationally; bank, mc_page, bios_en and upper_ram_en SHALL keep their values.
REQ-025 A MegaCart read and an I/O write cannot coincide; if they both appear, both registers SHALL update independently.

Reset
REQ-026 While reset_n_i=0 at a clk_i edge: mc_page=0, bank[n]=n, bios_en=1, upper_ram_en=0.
REQ-027 Outputs during reset SHALL follow the combinational decode of the reset state.
REQ-028 Reset asserted during an access SHALL win over any concurrent register update.

Configuration
REQ-029 Macro CV_SGM_EN. When defined, an I/O write to port 53 SHALL load upper_ram_en with d_i[0]; it SHALL be ignored in mode 2.
REQ-030 When CV_SGM_EN is not defined, upper_ram_en SHALL be constant 0, port 53 SHALL be ignored, and 0000-1FFF SHALL still switch between BIOS and RAM via bios_en.

Verification
REQ-031 After reset, mode 0, read 0000 -> bios_ce_n_o=0; then OUT 7F,00 and read 0000 -> ram_ce_n_o=0.
REQ-032 Mode 1, cart_pages_i=0F: read FFC5 then read C000 -> rom_page_o=05; read 8000 -> rom_page_o=0F.
REQ-033 Mode 1, cart_pages_i=07: read FFFE -> the next read of C000 gives rom_page_o=06.
REQ-034 Mode 2: write 09 to FFFE, then read 4000 -> rom_page_o=09 & mask, and the write gives ram_ce_n_o=0; bios_en_o=0.
REQ-035 CV_SGM_EN defined: OUT 53,01, then read 9000 -> ram_ce_n_o=0. Without the macro: OUT 53,01 -> rom_ce_n_o=0.
REQ-036 Assert reset_n_i mid-sequence after bank and page writes -> all registers return to their REQ-026 values on the next edge.

Source files
------------

// File: rtl/cv_mem_mapper_if.sv
// ----------------------------------------------------------------------------
// cv_mem_mapper_if
//   Z80-side bus bundle for the ColecoVision cartridge/SGM memory mapper.
//   master : CPU side, drives mode, address, data, page mask and strobes.
//   slave  : mapper side, returns ROM page, chip enables and SGM state bits.
//   Parameter PAGE_W : ROM page number width in 16 KB units.
// ----------------------------------------------------------------------------
interface cv_mem_mapper_if #(
    parameter int PAGE_W = 6
);
    logic [1:0]        mode_i;
    logic [15:0]       a_i;
    logic [7:0]        d_i;
    logic [PAGE_W-1:0] cart_pages_i;
    logic              mreq_n_i;
    logic              iorq_n_i;
    logic              rd_n_i;
    logic              wr_n_i;
    logic              rfsh_n_i;
    logic [PAGE_W-1:0] rom_page_o;
    logic              rom_ce_n_o;
    logic              bios_ce_n_o;
    logic              ram_ce_n_o;
    logic              bios_en_o;
    logic              upper_ram_en_o;

    modport master (
        output mode_i, a_i, d_i, cart_pages_i,
               mreq_n_i, iorq_n_i, rd_n_i, wr_n_i, rfsh_n_i,
        input  rom_page_o, rom_ce_n_o, bios_ce_n_o, ram_ce_n_o,
               bios_en_o, upper_ram_en_o
    );

    modport slave (
        input  mode_i, a_i, d_i, cart_pages_i,
               mreq_n_i, iorq_n_i, rd_n_i, wr_n_i, rfsh_n_i,
        output rom_page_o, rom_ce_n_o, bios_ce_n_o, ram_ce_n_o,
               bios_en_o, upper_ram_en_o
    );
endinterface

// File: rtl/cv_mem_mapper.sv
// ----------------------------------------------------------------------------
// cv_mem_mapper
//   ColecoVision memory mapper: BIOS/RAM/ROM chip-enable decode plus the
//   MegaCart (mode 1) and Sega (mode 2) cartridge bank registers.
//   Modes 0 and 3 are plain Coleco (32 KB cart at 8000-FFFF).
//
//   Ports:
//     clk_i      system clock
//     reset_n_i  synchronous active-low reset
//     bus        cv_mem_mapper_if.slave (Z80 strobes/address/data in,
//                rom page, chip enables and SGM state out)
//   Parameters:
//     PAGE_W     ROM page width in 16 KB units (<= 8)
//     SEGA_BANKS number of Sega slot registers, 1..3
//   Build option:
//     CV_SGM_EN  adds the port-53 upper-RAM enable (Super Game Module);
//                without it upper_ram_en is tied low.
// ----------------------------------------------------------------------------
module cv_mem_mapper #(
    parameter int PAGE_W     = 6,
    parameter int SEGA_BANKS = 3
) (
    input logic              clk_i,
    input logic              reset_n_i,
    cv_mem_mapper_if.slave   bus
);
    logic                   mem_acc;
    logic                   io_wr;
    logic                   mc_mode;
    logic                   sega_mode;
    logic [PAGE_W-1:0]      mc_page_q;
    logic                   bios_en_q;
    logic                   upper_ram_en_q;
    logic [3:0][PAGE_W-1:0] slot_page;
    logic [PAGE_W-1:0]      page;

    // Refresh cycles drive mreq low too; they are not accesses.
    assign mem_acc   = !bus.mreq_n_i && bus.rfsh_n_i;
    assign io_wr     = !bus.iorq_n_i && !bus.wr_n_i && bus.mreq_n_i;
    assign mc_mode   = (bus.mode_i == 2'd1);
    assign sega_mode = (bus.mode_i == 2'd2);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            mc_page_q <= '0;
            bios_en_q <= 1'b1;
        end else begin
            // MegaCart: any read in FFC0-FFFF selects the page from a_i[5:0].
            // The width cast zero-fills when PAGE_W exceeds the 6 address bits.
            if (mc_mode && mem_acc && !bus.rd_n_i && (bus.a_i[15:6] == 10'h3FF))
                mc_page_q <= PAGE_W'(bus.a_i[5:0]) & bus.cart_pages_i;
            // Sega carts have no Coleco BIOS; keep it switched out.
            if (sega_mode)
                bios_en_q <= 1'b0;
            else if (io_wr && (bus.a_i[7:0] == 8'h7F))
                bios_en_q <= bus.d_i[1];
        end
    end

`ifdef CV_SGM_EN
    always_ff @(posedge clk_i) begin
        if (!reset_n_i)
            upper_ram_en_q <= 1'b0;
        else if (!sega_mode && io_wr && (bus.a_i[7:0] == 8'h53))
            upper_ram_en_q <= bus.d_i[0];
    end
`else
    assign upper_ram_en_q = 1'b0;
`endif

    // Sega slot registers; slots without a register map to a fixed page
    // equal to the slot index.
    for (genvar g = 0; g < 4; g++) begin : g_slot
        if (g < SEGA_BANKS) begin : g_reg
            logic [PAGE_W-1:0] bank_q;
            always_ff @(posedge clk_i) begin
                if (!reset_n_i)
                    bank_q <= PAGE_W'(g);
                else if (sega_mode && mem_acc && !bus.wr_n_i &&
                         (bus.a_i == 16'hFFFD + 16'(g)))
                    bank_q <= PAGE_W'(bus.d_i);
            end
            assign slot_page[g] = bank_q;
        end else begin : g_fixed
            assign slot_page[g] = PAGE_W'(g);
        end
    end

    always_comb begin
        page             = '0;
        bus.rom_ce_n_o   = 1'b1;
        bus.bios_ce_n_o  = 1'b1;
        bus.ram_ce_n_o   = 1'b1;

        if (sega_mode)
            page = slot_page[bus.a_i[15:14]] & bus.cart_pages_i;
        else if (mc_mode)
            page = bus.a_i[14] ? mc_page_q : bus.cart_pages_i;
        else
            page = PAGE_W'(bus.a_i[14]) & bus.cart_pages_i;

        if (mem_acc) begin
            if (sega_mode) begin
                if (bus.a_i[15:14] == 2'b11) bus.ram_ce_n_o = 1'b0;
                else                         bus.rom_ce_n_o = 1'b0;
            end else if (bus.a_i[15:13] == 3'b000) begin
                if (bios_en_q) bus.bios_ce_n_o = 1'b0;
                else           bus.ram_ce_n_o  = 1'b0;
            end else if (!bus.a_i[15]) begin
                bus.ram_ce_n_o = 1'b0;
            end else if (upper_ram_en_q) begin
                bus.ram_ce_n_o = 1'b0;
            end else begin
                bus.rom_ce_n_o = 1'b0;
            end
        end
    end

    assign bus.rom_page_o     = page;
    assign bus.bios_en_o      = bios_en_q;
    assign bus.upper_ram_en_o = upper_ram_en_q;
endmodule

// File: tb/tb_cv_mem_mapper.sv
module tb_cv_mem_mapper;
    localparam int PW = 6;
    localparam int SB = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;
    int   cur_mode = 0;
    int   cur_cart = 'h3F;

    // reference state
    int m_mc, m_bios, m_upper;
    int m_bank[SB];

    cv_mem_mapper_if #(.PAGE_W(PW)) bus ();

    cv_mem_mapper #(.PAGE_W(PW), .SEGA_BANKS(SB)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic lit(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference state update from the rules, applied at each clock edge.
    task automatic update_model();
        int a, d, mode, mask;
        bit acc, iowr;
        a = bus.a_i; d = bus.d_i; mode = bus.mode_i; mask = bus.cart_pages_i;
        acc  = !bus.mreq_n_i && bus.rfsh_n_i;
        iowr = !bus.iorq_n_i && !bus.wr_n_i && bus.mreq_n_i;
        if (!rst_n) begin
            m_mc = 0; m_bios = 1; m_upper = 0;
            for (int i = 0; i < SB; i++) m_bank[i] = i;
            chk_en = 1'b1;
        end else begin
            if (mode == 2) m_bios = 0;
            else if (iowr && (a % 256) == 'h7F) m_bios = (d >> 1) & 1;
`ifdef CV_SGM_EN
            if (mode != 2 && iowr && (a % 256) == 'h53) m_upper = d & 1;
`endif
            if (mode == 1 && acc && !bus.rd_n_i && a >= 'hFFC0)
                m_mc = (a % 64) & mask;
            if (mode == 2 && acc && !bus.wr_n_i && a >= 'hFFFD && (a - 'hFFFD) < SB)
                m_bank[a - 'hFFFD] = d % (1 << PW);
        end
    endtask

    // Expected decode from the memory map, compared every cycle.
    task automatic check_model();
        int a, mode, mask, slot;
        int e_rom, e_bios, e_ram, e_page;
        a = bus.a_i; mode = bus.mode_i; mask = bus.cart_pages_i;
        e_rom = 1; e_bios = 1; e_ram = 1; e_page = 0;
        if (!bus.mreq_n_i && bus.rfsh_n_i) begin
            if (mode == 2) begin
                if (a >= 'hC000) e_ram = 0;
                else begin
                    e_rom = 0;
                    slot = a / 'h4000;
                    e_page = ((slot < SB) ? m_bank[slot] : slot) & mask;
                end
            end else if (a < 'h2000) begin
                if (m_bios != 0) e_bios = 0; else e_ram = 0;
            end else if (a < 'h8000) e_ram = 0;
            else if (m_upper != 0) e_ram = 0;
            else begin
                e_rom = 0;
                if (mode == 1) e_page = (a < 'hC000) ? mask : m_mc;
                else           e_page = ((a >= 'hC000) ? 1 : 0) & mask;
            end
        end
        lit("ctl", {bus.rom_ce_n_o, bus.bios_ce_n_o, bus.ram_ce_n_o,
                    bus.bios_en_o, bus.upper_ram_en_o},
            {e_rom[0], e_bios[0], e_ram[0], m_bios[0], m_upper[0]});
        if (e_rom == 0) lit("page", bus.rom_page_o, e_page);
    endtask

    // One bus cycle: edge (model update), drive, then decode check at negedge.
    task automatic op(input bit rst, input int mode, input int a, input int d,
                      input bit mreq, input bit iorq, input bit rd, input bit wr,
                      input bit rfsh);
        @(posedge clk);
        update_model();
        #1;
        rst_n = rst;
        bus.mode_i = 2'(mode); bus.a_i = 16'(a); bus.d_i = 8'(d);
        bus.cart_pages_i = PW'(cur_cart);
        bus.mreq_n_i = mreq; bus.iorq_n_i = iorq; bus.rd_n_i = rd;
        bus.wr_n_i = wr; bus.rfsh_n_i = rfsh;
        @(negedge clk);
        if (chk_en) check_model();
    endtask

    task automatic rd_mem(input int a);          op(1, cur_mode, a, 0, 0, 1, 0, 1, 1); endtask
    task automatic wr_mem(input int a, input int d); op(1, cur_mode, a, d, 0, 1, 1, 0, 1); endtask
    task automatic out_io(input int p, input int d); op(1, cur_mode, p, d, 1, 0, 1, 0, 1); endtask
    task automatic idle(input bit rst);          op(rst, cur_mode, 0, 0, 1, 1, 1, 1, 1); endtask

    initial begin
        int kind, a, t;
        int carts[8] = '{0, 1, 3, 7, 'h0F, 'h1F, 'h3F, 'h2A};
        bus.mode_i = 0; bus.a_i = 0; bus.d_i = 0; bus.cart_pages_i = PW'(cur_cart);
        bus.mreq_n_i = 1; bus.iorq_n_i = 1; bus.rd_n_i = 1; bus.wr_n_i = 1; bus.rfsh_n_i = 1;

        // BIOS switch-out via port 7F
        cur_mode = 0;
        idle(0); idle(0);
        rd_mem('h0000);
        lit("rst_bios_ce", bus.bios_ce_n_o, 0);
        lit("rst_bios_en", bus.bios_en_o, 1);
        lit("rst_upper", bus.upper_ram_en_o, 0);
        out_io('h7F, 'h00);
        rd_mem('h0000);
        lit("bios_off_ram", bus.ram_ce_n_o, 0);
        lit("bios_off_bios", bus.bios_ce_n_o, 1);

        // MegaCart paging
        cur_mode = 1; cur_cart = 'h0F;
        rd_mem('hFFC5);
        rd_mem('hC000);
        lit("mc_page5", bus.rom_page_o, 'h05);
        rd_mem('h8000);
        lit("mc_last", bus.rom_page_o, 'h0F);
        cur_cart = 'h07;
        rd_mem('hFFFE);
        rd_mem('hC000);
        lit("mc_mask", bus.rom_page_o, 'h06);

        // Sega bank write
        cur_mode = 2; cur_cart = 'h3F;
        wr_mem('hFFFE, 'h09);
        lit("sega_wr_ram", bus.ram_ce_n_o, 0);
        rd_mem('h4000);
        lit("sega_page", bus.rom_page_o, 'h09);
        lit("sega_rom_ce", bus.rom_ce_n_o, 0);
        lit("sega_bios_en", bus.bios_en_o, 0);

        // SGM upper RAM
        cur_mode = 0;
        out_io('h53, 'h01);
        rd_mem('h9000);
`ifdef CV_SGM_EN
        lit("sgm_ram", bus.ram_ce_n_o, 0);
`else
        lit("sgm_rom", bus.rom_ce_n_o, 0);
`endif

        // Reset beats a concurrent bank write
        cur_mode = 1; rd_mem('hFFC3);
        cur_mode = 2; wr_mem('hFFFD, 'h05);
        op(0, 2, 'hFFFE, 'h07, 0, 1, 1, 0, 1);
        cur_mode = 1; rd_mem('hC000);
        lit("rst2_mc", bus.rom_page_o, 0);
        lit("rst2_bios", bus.bios_en_o, 1);
        lit("rst2_upper", bus.upper_ram_en_o, 0);
        cur_mode = 2;
        rd_mem('h0000); lit("rst2_bank0", bus.rom_page_o, 0);
        rd_mem('h4000); lit("rst2_bank1", bus.rom_page_o, 1);
        rd_mem('h8000); lit("rst2_bank2", bus.rom_page_o, 2);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 15) == 0) cur_mode = $urandom_range(0, 3);
            if ($urandom_range(0, 31) == 0) cur_cart = carts[$urandom_range(0, 7)];
            kind = $urandom_range(0, 5);
            case (kind)
                0: a = 'hFFC0 + $urandom_range(0, 63);
                1: a = 'hFFFD + $urandom_range(0, 2);
                2: a = $urandom_range(0, 'h1FFF);
                default: a = $urandom_range(0, 'hFFFF);
            endcase
            t = $urandom_range(0, 6);
            case (t)
                0: idle($urandom_range(0, 63) != 0);
                1, 2: op($urandom_range(0, 63) != 0, cur_mode, a, 0, 0, 1, 0, 1, 1);
                3: op($urandom_range(0, 63) != 0, cur_mode, a, $urandom_range(0, 255), 0, 1, 1, 0, 1);
                4: op($urandom_range(0, 63) != 0, cur_mode,
                      ($urandom_range(0, 1) != 0) ? 'h7F : 'h53, $urandom_range(0, 255), 1, 0, 1, 0, 1);
                5: op(1, cur_mode, a, 0, 0, 1, 1, 1, 0);
                default: op($urandom_range(0, 63) != 0, cur_mode, a, $urandom_range(0, 255),
                            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
